// File: rtl/cal_pkg.sv
// Shared widths, FSM state and coefficient-select encoding for the input calibration stage.
package cal_pkg;

    localparam int unsigned NCH       = 4;
    localparam int unsigned CH_W      = 2;
    localparam int unsigned W         = 16;
    localparam int unsigned GAIN_FRAC = 14;
    localparam int unsigned ROUND_K   = 8192;
    localparam int unsigned DIFF_W    = W + 1;
    localparam int unsigned PROD_W    = DIFF_W + W;
    localparam int unsigned SUM_W     = PROD_W + 1;

    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(2 ** (W - 1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-(2 ** (W - 1)));

    typedef logic signed [W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } cal_state_e;

    // cal_sel: bit 2 picks gain (1) or offset (0), bits 1:0 pick the channel
    typedef struct packed {
        logic            is_gain;
        logic [CH_W-1:0] ch;
    } cal_sel_t;

    function automatic sample_t sat_sample(input logic signed [SUM_W-1:0] v);
        sample_t r;
        if (v > SAT_HI) begin
            r = sample_t'(SAT_HI[W-1:0]);
        end else if (v < SAT_LO) begin
            r = sample_t'(SAT_LO[W-1:0]);
        end else begin
            r = sample_t'(v[W-1:0]);
        end
        return r;
    endfunction

endpackage

// File: rtl/cal_mac.sv
// Two-stage subtract/multiply then round/saturate datapath, shared by all channels.
module cal_mac
    import cal_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  sample_t         in_s,
    input  sample_t         offset,
    input  sample_t         gain,
    input  logic            valid,
    input  logic [CH_W-1:0] ch,
    output sample_t         result_c,
    output logic            valid_c,
    output logic [CH_W-1:0] ch_c
);

    localparam logic signed [SUM_W-1:0] ROUND_ADD = SUM_W'(ROUND_K);

    logic signed [DIFF_W-1:0] diff_c;
    logic signed [PROD_W-1:0] prod_d, prod_q;
    logic                     valid_d, valid_q;
    logic [CH_W-1:0]          ch_d, ch_q;
    logic signed [SUM_W-1:0]  sum_c;
    logic signed [SUM_W-1:0]  shifted_c;

    // Stage 1: 17-bit difference cannot overflow; 33-bit product holds the full result
    always_comb begin
        diff_c  = DIFF_W'(in_s) - DIFF_W'(offset);
        prod_d  = PROD_W'(diff_c) * PROD_W'(gain);
        valid_d = valid;
        ch_d    = ch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
        end else begin
            prod_q  <= prod_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
        end
    end

    // Stage 2: add half an LSB then floor-shift, giving round-half-up
    always_comb begin
        sum_c     = SUM_W'(prod_q) + ROUND_ADD;
        shifted_c = sum_c >>> GAIN_FRAC;
        result_c  = sat_sample(shifted_c);
        valid_c   = valid_q;
        ch_c      = ch_q;
    end

endmodule

// File: rtl/cal_in.sv
// Per-channel input calibration: (raw - offset) * gain, rounded and saturated,
// four channels time-shared through one multiplier and published atomically.
module cal_in
    import cal_pkg::*;
#(
    parameter sample_t OFFSET_DEFAULT = 16'sd3500,
    parameter sample_t GAIN_DEFAULT   = 16'sd16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_clk,
    input  logic signed [15:0] sample_in0,
    input  logic signed [15:0] sample_in1,
    input  logic signed [15:0] sample_in2,
    input  logic signed [15:0] sample_in3,
    input  logic        cal_we,
    input  logic [2:0]  cal_sel,
    input  logic signed [15:0] cal_wdata,
    output logic signed [15:0] sample_out0,
    output logic signed [15:0] sample_out1,
    output logic signed [15:0] sample_out2,
    output logic signed [15:0] sample_out3,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun
);

    cal_state_e      state_d, state_q;
    logic [CH_W-1:0] ch_d, ch_q;
    logic            sample_clk_d, sample_clk_q;
    logic            busy_d, busy_q;
    logic            out_valid_d, out_valid_q;
    logic            overrun_d, overrun_q;

    sample_t in_c       [NCH];
    sample_t off_d      [NCH];
    sample_t off_q      [NCH];
    sample_t gain_d     [NCH];
    sample_t gain_q     [NCH];
    sample_t snap_in_d  [NCH];
    sample_t snap_in_q  [NCH];
    sample_t snap_off_d [NCH];
    sample_t snap_off_q [NCH];
    sample_t snap_gain_d[NCH];
    sample_t snap_gain_q[NCH];
    sample_t shadow_d   [NCH];
    sample_t shadow_q   [NCH];
    sample_t out_d      [NCH];
    sample_t out_q      [NCH];

    logic            edge_c;
    cal_sel_t        sel_c;
    logic            mac_valid_in;
    sample_t         mac_result;
    logic            mac_valid_out;
    logic [CH_W-1:0] mac_ch_out;

    assign in_c[0] = sample_in0;
    assign in_c[1] = sample_in1;
    assign in_c[2] = sample_in2;
    assign in_c[3] = sample_in3;
    assign sel_c   = cal_sel_t'(cal_sel);
    assign edge_c  = sample_clk & ~sample_clk_q;

    cal_mac u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_s     (snap_in_q[ch_q]),
        .offset   (snap_off_q[ch_q]),
        .gain     (snap_gain_q[ch_q]),
        .valid    (mac_valid_in),
        .ch       (ch_q),
        .result_c (mac_result),
        .valid_c  (mac_valid_out),
        .ch_c     (mac_ch_out)
    );

    // Sequencer: snapshot on an idle edge, issue four channels, publish once the pipe empties
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        sample_clk_d = sample_clk;
        out_valid_d  = 1'b0;
        overrun_d    = 1'b0;
        mac_valid_in = 1'b0;
        snap_in_d    = snap_in_q;
        snap_off_d   = snap_off_q;
        snap_gain_d  = snap_gain_q;
        shadow_d     = shadow_q;
        out_d        = out_q;
        off_d        = off_q;
        gain_d       = gain_q;

        case (state_q)
            IDLE: begin
                if (edge_c) begin
                    snap_in_d   = in_c;
                    snap_off_d  = off_q;
                    snap_gain_d = gain_q;
                    ch_d        = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                overrun_d    = edge_c;
                mac_valid_in = 1'b1;
                ch_d         = ch_q + CH_W'(1);
                if (ch_q == CH_W'(NCH - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                overrun_d = edge_c;
                if (!mac_valid_out) begin
                    out_d       = shadow_q;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (mac_valid_out) begin
            shadow_d[mac_ch_out] = mac_result;
        end

        // Live coefficients update regardless of state; the running conversion uses its snapshot
        if (cal_we) begin
            if (sel_c.is_gain) begin
                gain_d[sel_c.ch] = cal_wdata;
            end else begin
                off_d[sel_c.ch] = cal_wdata;
            end
        end

        busy_d = (state_d != IDLE) || out_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            sample_clk_q <= 1'b1;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            snap_in_q    <= '{default: '0};
            snap_off_q   <= '{default: '0};
            snap_gain_q  <= '{default: '0};
            shadow_q     <= '{default: '0};
            out_q        <= '{default: '0};
            off_q        <= '{default: OFFSET_DEFAULT};
            gain_q       <= '{default: GAIN_DEFAULT};
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            sample_clk_q <= sample_clk_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            snap_in_q    <= snap_in_d;
            snap_off_q   <= snap_off_d;
            snap_gain_q  <= snap_gain_d;
            shadow_q     <= shadow_d;
            out_q        <= out_d;
            off_q        <= off_d;
            gain_q       <= gain_d;
        end
    end

    assign sample_out0 = out_q[0];
    assign sample_out1 = out_q[1];
    assign sample_out2 = out_q[2];
    assign sample_out3 = out_q[3];
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule
